// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and operand-sign helpers for the M-extension sequencer.
package muldiv_pkg;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int unsigned ITER_COUNT = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIXUP,
    ST_DONE
  } muldiv_state_t;

  // rs1 is treated as signed for every op except the unsigned variants
  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return signed_a(f3) && (f3 != F3_MULHSU);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer handshake and result bus.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            flush;
  logic            stall_req;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_val, rs2_val, flush,
    input  stall_req, busy, done, result
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, flush,
    output stall_req, busy, done, result
  );
endinterface

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, divisor};
    fits     = ~diff[XLEN];
    rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], fits};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer with EX-stall handshake.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply path; divide is always iterative.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clock,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);
  localparam int unsigned AW = 2 * XLEN;

  muldiv_state_t   state;
  logic [5:0]      cnt;
  logic [AW-1:0]   acc;   // MUL: {partial, multiplier}; DIV: {remainder, quotient}
  logic [XLEN-1:0] opb;   // multiplicand or divisor magnitude
  logic [2:0]      op;
  logic            neg_a;
  logic            neg_b;

  logic            start_ok;
  logic            in_neg_a;
  logic            in_neg_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] early_val;
  logic [XLEN:0]   mul_sum;
  logic [AW-1:0]   mul_next;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [AW-1:0]   prod;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fix_val;
`ifdef MULDIV_FAST_MUL_EN
  logic [AW-1:0]   fprod;
  logic [XLEN-1:0] fast_val;
`endif

  div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (acc[AW-1:XLEN]),
    .quo      (acc[XLEN-1:0]),
    .divisor  (opb),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_comb begin
    start_ok  = bus.start & ~bus.flush;
    in_neg_a  = signed_a(bus.funct3) & bus.rs1_val[XLEN-1];
    in_neg_b  = signed_b(bus.funct3) & bus.rs2_val[XLEN-1];
    mag_a     = in_neg_a ? (XLEN'(0) - bus.rs1_val) : bus.rs1_val;
    mag_b     = in_neg_b ? (XLEN'(0) - bus.rs2_val) : bus.rs2_val;
    div_zero  = (bus.rs2_val == '0);
    div_ovf   = signed_b(bus.funct3) && (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                && (bus.rs2_val == '1);
    // Divide-by-zero takes priority; overflow quotient is the dividend itself
    if (div_zero) early_val = bus.funct3[1] ? bus.rs1_val : '1;
    else          early_val = bus.funct3[1] ? '0 : bus.rs1_val;

    mul_sum  = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};

    prod    = (neg_a ^ neg_b) ? (AW'(0) - acc) : acc;
    quo_fix = (neg_a ^ neg_b) ? (XLEN'(0) - acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem_fix = neg_a ? (XLEN'(0) - acc[AW-1:XLEN]) : acc[AW-1:XLEN];
    case (op)
      F3_MUL:                        fix_val = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_val = prod[AW-1:XLEN];
      F3_DIV, F3_DIVU:               fix_val = quo_fix;
      default:                       fix_val = rem_fix;
    endcase

`ifdef MULDIV_FAST_MUL_EN
    fprod    = AW'($signed({in_neg_a, bus.rs1_val & {XLEN{1'b1}}} & {(signed_a(bus.funct3) & bus.rs1_val[XLEN-1]), {XLEN{1'b1}}}))
             * AW'($signed({signed_b(bus.funct3) & bus.rs2_val[XLEN-1], bus.rs2_val}));
    fast_val = (bus.funct3 == F3_MUL) ? fprod[XLEN-1:0] : fprod[AW-1:XLEN];
`endif

    bus.stall_req = reset & (((state == ST_IDLE) & start_ok) | (state == ST_MUL)
                             | (state == ST_DIV) | (state == ST_FIXUP));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      acc        <= '0;
      opb        <= '0;
      op         <= '0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      bus.done   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.result <= '0;
    end else begin
      bus.done <= 1'b0;
      if (bus.flush) begin
        state    <= ST_IDLE;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              op       <= bus.funct3;
              neg_a    <= in_neg_a;
              neg_b    <= in_neg_b;
              cnt      <= '0;
              bus.busy <= 1'b1;
              if (bus.funct3[2]) begin
                if (div_zero || div_ovf) begin
                  bus.result <= early_val;
                  bus.done   <= 1'b1;
                  state      <= ST_DONE;
                end else begin
                  acc   <= {{XLEN{1'b0}}, mag_a};
                  opb   <= mag_b;
                  state <= ST_DIV;
                end
              end else begin
`ifdef MULDIV_FAST_MUL_EN
                bus.result <= fast_val;
                bus.done   <= 1'b1;
                state      <= ST_DONE;
`else
                acc   <= {{XLEN{1'b0}}, mag_b};
                opb   <= mag_a;
                state <= ST_MUL;
`endif
              end
            end
          end
          ST_MUL, ST_DIV: begin
            acc <= (state == ST_MUL) ? mul_next : {rem_next, quo_next};
            cnt <= cnt + 6'd1;
            if (cnt == 6'(ITER_COUNT - 1)) state <= ST_FIXUP;
          end
          ST_FIXUP: begin
            bus.result <= fix_val;
            bus.done   <= 1'b1;
            state      <= ST_DONE;
          end
          default: begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
